// File: rtl/truth_table_sequencer.sv
// Self-test sequencer: sweeps every input vector of a combinational block and checks
// its outputs against a packed truth table. Optional macro TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sequencer #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 3,
  parameter int SETTLE_CYC = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_idx,
  output logic [N_OUT-1:0]  first_fail_val
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // SETTLE | holding dut_in while the datapath settles
  // SAMPLE | comparing dut_out against the table entry for dut_in
  // DONE   | results held until start or rst
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int              CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic [N_OUT-1:0]  ffv_q, ffv_d;
  logic [N_OUT-1:0]  exp_vec;
  logic              mismatch;

  assign exp_vec  = EXPECTED[int'(dut_in_q)*N_OUT +: N_OUT];
  assign mismatch = (dut_out != exp_vec);

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SETTLE;
          dut_in_d = '0;
          cnt_d    = RELOAD;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          ffi_d    = '0;
          ffv_d    = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            ffi_d = dut_in_q;
            ffv_d = dut_out;
          end
        end
`ifdef TT_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else
`endif
        if (dut_in_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = SETTLE;
          dut_in_d = dut_in_q + 1'b1;
          cnt_d    = RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffi_q    <= '0;
      ffv_q    <= '0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_val = ffv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a model datapath with injectable faults, checked
// against a sweep-level reference computed from the fault list.
module tb_truth_table_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int S     = 1;
  localparam int P     = S + 1;
  localparam int NV    = 2**N_IN;

  function automatic logic [NV*N_OUT-1:0] gen_exp();
    logic [NV*N_OUT-1:0] t;
    t = '0;
    for (int i = 0; i < NV; i++) t[i*N_OUT +: N_OUT] = 3'((i*3 + 1) % 8);
    return t;
  endfunction
  localparam logic [NV*N_OUT-1:0] EXP = gen_exp();

  logic clk = 1'b0;
  logic rst, start;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic busy, done, pass;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail_idx;
  logic [N_OUT-1:0] first_fail_val;

  logic             fault_m [NV];
  logic [N_OUT-1:0] fval_m  [NV];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(S), .EXPECTED(EXP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_val(first_fail_val)
  );

  function automatic logic [N_OUT-1:0] exp_of(input int i);
    return 3'((i*3 + 1) % 8);
  endfunction

  // Model datapath: correct table unless a fault is planted on that vector.
  always_comb begin
    dut_out = exp_of(int'(dut_in));
    if (fault_m[dut_in]) dut_out = fval_m[dut_in];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < NV; i++) begin
      fault_m[i] = 1'b0;
      fval_m[i]  = '0;
    end
  endtask

  task automatic plant(input int i, input logic [N_OUT-1:0] v);
    fault_m[i] = 1'b1;
    fval_m[i]  = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_ffi"}, 32'(first_fail_idx), 0);
    chk({tag, "_ffv"}, 32'(first_fail_val), 0);
  endtask

  // Pulses start, then follows the sweep edge by edge. Edge 1 accepts start;
  // vector k is sampled at edge 1+(k+1)*P, so done appears after that edge.
  task automatic sweep(input string tag, input int repulse);
    int nerr, ffi, ffv, last_v, done_e;
    nerr = 0; ffi = 0; ffv = 0; last_v = NV - 1;
    for (int i = 0; i < NV; i++) begin
      if (fault_m[i]) begin
        if (nerr == 0) begin
          ffi = i;
          ffv = int'(fval_m[i]);
        end
        nerr++;
`ifdef TT_STOP_ON_FAIL_EN
        last_v = i;
        break;
`endif
      end
    end
    done_e = 1 + (last_v + 1) * P;
    start = 1'b1;
    step();
    chk({tag, "_clr_done"}, 32'(done), 0);
    chk({tag, "_clr_err"}, 32'(err_count), 0);
    for (int e = 1; e <= done_e; e++) begin
      if (e < done_e) begin
        chk({tag, "_dut_in"}, 32'(dut_in), 32'((e - 1) / P));
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_done_early"}, 32'(done), 0);
      end else begin
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_dut_in_end"}, 32'(dut_in), 32'(last_v));
        chk({tag, "_pass"}, 32'(pass), 32'(nerr == 0));
        chk({tag, "_err"}, 32'(err_count), 32'(nerr));
        chk({tag, "_ffi"}, 32'(first_fail_idx), 32'(ffi));
        chk({tag, "_ffv"}, 32'(first_fail_val), 32'(ffv));
      end
      if (e < done_e) begin
        start = (e == repulse);
        step();
      end
    end
    start = 1'b0;
    step();
    step();
    chk({tag, "_done_hold"}, 32'(done), 1);
    chk({tag, "_err_hold"}, 32'(err_count), 32'(nerr));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("reset");
    step();
    chk({"idle_dut_in"}, 32'(dut_in), 0);

    sweep("clean", 0);

    plant(5, 3'b111);
    plant(12, 3'b111);
    sweep("f5_12", 0);

    clear_faults();
    sweep("after_fail", 0);

    sweep("repulse", 10);

    // Abort mid-sweep with a one-cycle reset, then a fresh full sweep.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e < 15; e++) step();
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("abort");
    step();
    step();
    chk("abort_idle_busy", 32'(busy), 0);
    sweep("post_abort", 0);

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int i = 0; i < NV; i++)
        if ($urandom_range(0, 3) == 0) plant(i, exp_of(i) ^ 3'($urandom_range(1, 7)));
      sweep($sformatf("rand%0d", r), (r % 2 == 1) ? int'($urandom_range(2, 20)) : 0);
    end

    clear_faults();
    for (int i = 0; i < NV; i++) plant(i, ~exp_of(i));
    sweep("all_fail", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
